// File: rtl/relation_tally_if.sv
// Handshake bundle for relation_tally: sample flags in, tallies and report handshake out.
// The master side drives samples and rpt_ready; the slave side is the tally block.
interface relation_tally_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             in_valid;
  logic             gray;
  logic             excess_3;
  logic             more;
  logic             less;
  logic             no_relation;
  logic             busy;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] gray_cnt;
  logic [CNT_W-1:0] ex3_cnt;
  logic [CNT_W-1:0] more_cnt;
  logic [CNT_W-1:0] less_cnt;
  logic [CNT_W-1:0] none_cnt;
  logic [2:0]       dominant;
  logic             err;
  logic [CNT_W-1:0] max_run;

  modport master (
    output start, in_valid, gray, excess_3, more, less, no_relation, rpt_ready,
    input  busy, rpt_valid, gray_cnt, ex3_cnt, more_cnt, less_cnt, none_cnt,
           dominant, err, max_run
  );

  modport slave (
    input  start, in_valid, gray, excess_3, more, less, no_relation, rpt_ready,
    output busy, rpt_valid, gray_cnt, ex3_cnt, more_cnt, less_cnt, none_cnt,
           dominant, err, max_run
  );
endinterface

// File: rtl/relation_tally.sv
// Tallies code-relation flags over a window of accepted samples and reports them via valid/ready.
// Optional longest-run-of-"more" tracking is enabled by defining RUN_TRACK_EN.
module relation_tally #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input logic             clk,
  input logic             rst_n,
  relation_tally_if.slave bus
);
  localparam int               SMP_W    = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;

  state_t           state;
  logic [SMP_W-1:0] smp_cnt;
  logic [CNT_W-1:0] gray_q, ex3_q, more_q, less_q, none_q;
  logic [CNT_W-1:0] gray_nx, ex3_nx, more_nx, less_nx, none_nx;
  logic [CNT_W-1:0] best;
  logic [2:0]       dom_q, dom_nx;
  logic             busy_q, rpt_valid_q, err_q;
  logic             any_rel, restart, accept, mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
  endfunction

  // A start outside REPORT always wins over a same-cycle sample, which is dropped.
  assign any_rel  = bus.gray | bus.excess_3 | bus.more | bus.less;
  assign restart  = bus.start && (state != REPORT);
  assign accept   = (state == COUNT) && bus.in_valid && !bus.start;
  assign mismatch = bus.no_relation != ~any_rel;

  assign gray_nx = sat_inc(gray_q, bus.gray);
  assign ex3_nx  = sat_inc(ex3_q,  bus.excess_3);
  assign more_nx = sat_inc(more_q, bus.more);
  assign less_nx = sat_inc(less_q, bus.less);
  assign none_nx = sat_inc(none_q, ~any_rel);

  // Dominant is taken from the post-update tallies so the closing sample counts; strict > keeps ties low.
  always_comb begin
    dom_nx = 3'd0;
    best   = gray_nx;
    if (ex3_nx > best) begin
      dom_nx = 3'd1;
      best   = ex3_nx;
    end
    if (more_nx > best) begin
      dom_nx = 3'd2;
      best   = more_nx;
    end
    if (less_nx > best) begin
      dom_nx = 3'd3;
      best   = less_nx;
    end
    if (none_nx > best) begin
      dom_nx = 3'd4;
      best   = none_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      smp_cnt     <= '0;
      gray_q      <= '0;
      ex3_q       <= '0;
      more_q      <= '0;
      less_q      <= '0;
      none_q      <= '0;
      dom_q       <= '0;
      busy_q      <= 1'b0;
      rpt_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else if (restart) begin
      state   <= COUNT;
      smp_cnt <= '0;
      gray_q  <= '0;
      ex3_q   <= '0;
      more_q  <= '0;
      less_q  <= '0;
      none_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else if (accept) begin
      gray_q  <= gray_nx;
      ex3_q   <= ex3_nx;
      more_q  <= more_nx;
      less_q  <= less_nx;
      none_q  <= none_nx;
      err_q   <= err_q | mismatch;
      smp_cnt <= smp_cnt + SMP_W'(1);
      if (smp_cnt == SMP_LAST) begin
        state       <= REPORT;
        rpt_valid_q <= 1'b1;
        dom_q       <= dom_nx;
      end
    end else if ((state == REPORT) && bus.rpt_ready) begin
      state       <= IDLE;
      rpt_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.rpt_valid = rpt_valid_q;
  assign bus.gray_cnt  = gray_q;
  assign bus.ex3_cnt   = ex3_q;
  assign bus.more_cnt  = more_q;
  assign bus.less_cnt  = less_q;
  assign bus.none_cnt  = none_q;
  assign bus.dominant  = dom_q;
  assign bus.err       = err_q;

`ifdef RUN_TRACK_EN
  logic [CNT_W-1:0] cur_run_q, max_run_q, cur_run_nx;

  assign cur_run_nx = bus.more ? sat_inc(cur_run_q, 1'b1) : '0;

  // Run length only moves on accepted samples, so in_valid gaps do not break a run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_run_q <= '0;
      max_run_q <= '0;
    end else if (restart) begin
      cur_run_q <= '0;
      max_run_q <= '0;
    end else if (accept) begin
      cur_run_q <= cur_run_nx;
      max_run_q <= (cur_run_nx > max_run_q) ? cur_run_nx : max_run_q;
    end
  end

  assign bus.max_run = max_run_q;
`else
  assign bus.max_run = '0;
`endif
endmodule
